systolic_seq_ctrl: RTL and testbench

Sequencer for a ROWS x COLS weight-stationary int8 systolic array built from PE tiles. Each PE has a broadcast load, an 8-bit west/east activation path and a 32-bit north/south partial-sum path. On a start command the block:
- reads one weight set from the weight buffer and pulses the array load;
- streams num_vec activation vectors from the activation buffer (external skew registers feed the array's west edge);
- flags per-column result validity at the array's south edge until drained, then pulses done.

---
 rtl/systolic_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: weight load, activation feed, drain.
// Optional `define WEIGHT_REUSE_EN adds i_reuse_w to skip the weight read/load phases.
module systolic_seq_ctrl #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned VEC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [VEC_W-1:0] i_num_vec,
`ifdef WEIGHT_REUSE_EN
  input  logic             i_reuse_w,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_w_rd_en,
  output logic             o_pe_load,
  output logic             o_a_rd_en,
  output logic [VEC_W-1:0] o_a_rd_addr,
  output logic [COLS-1:0]  o_out_valid
);

  // One spare bit so cycle counts of N + ROWS + COLS never wrap.
  localparam int unsigned CntW = VEC_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StWread,
    StWload,
    StFeed,
    StDrain,
    StDone
  } state_e;

  state_e             r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [VEC_W-1:0]   r_num, w_num_nxt;
  logic [CntW-1:0]    w_num_ext, w_num_nxt_ext;
  logic               w_reuse;

  logic               w_busy_nxt, w_done_nxt, w_w_rd_en_nxt, w_pe_load_nxt, w_a_rd_en_nxt;
  logic [VEC_W-1:0]   w_a_rd_addr_nxt;
  logic [COLS-1:0]    w_out_valid_nxt;

`ifdef WEIGHT_REUSE_EN
  assign w_reuse = i_reuse_w;
`else
  assign w_reuse = 1'b0;
`endif

  assign w_num_ext     = {1'b0, r_num};
  assign w_num_nxt_ext = {1'b0, w_num_nxt};

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_num   <= w_num_nxt;
    end
  end

  // Next-state logic; r_cnt is the cycle offset from the first feed cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_num_nxt   = r_num;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_num_nxt = i_num_vec;
          w_cnt_nxt = '0;
          if (i_num_vec == '0) begin
            w_state_nxt = StDone;
          end else if (w_reuse) begin
            w_state_nxt = StFeed;
          end else begin
            w_state_nxt = StWread;
          end
        end
      end
      StWread: w_state_nxt = StWload;
      StWload: begin
        w_state_nxt = StFeed;
        w_cnt_nxt   = '0;
      end
      StFeed: begin
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == w_num_ext - CntW'(1)) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        w_cnt_nxt = r_cnt + CntW'(1);
        if (r_cnt == w_num_ext + CntW'(ROWS + COLS - 1)) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    w_busy_nxt      = (w_state_nxt != StIdle);
    w_done_nxt      = (w_state_nxt == StDone);
    w_w_rd_en_nxt   = (w_state_nxt == StWread);
    w_pe_load_nxt   = (w_state_nxt == StWload);
    w_a_rd_en_nxt   = (w_state_nxt == StFeed);
    w_a_rd_addr_nxt = (w_state_nxt == StFeed) ? w_cnt_nxt[VEC_W-1:0] : '0;
    w_out_valid_nxt = '0;
    if (w_state_nxt inside {StFeed, StDrain}) begin
      // Column c holds vector t at offset 1 + ROWS + c + t.
      for (int c = 0; c < int'(COLS); c++) begin
        w_out_valid_nxt[c] = (w_cnt_nxt >= CntW'(ROWS + 1 + c)) &&
                             (w_cnt_nxt <= w_num_nxt_ext + CntW'(ROWS + c));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_w_rd_en   <= 1'b0;
      o_pe_load   <= 1'b0;
      o_a_rd_en   <= 1'b0;
      o_a_rd_addr <= '0;
      o_out_valid <= '0;
    end else begin
      o_busy      <= w_busy_nxt;
      o_done      <= w_done_nxt;
      o_w_rd_en   <= w_w_rd_en_nxt;
      o_pe_load   <= w_pe_load_nxt;
      o_a_rd_en   <= w_a_rd_en_nxt;
      o_a_rd_addr <= w_a_rd_addr_nxt;
      o_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl against a cycle-offset reference model.
module tb_systolic_seq_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int VEC_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [VEC_W-1:0] num_vec = '0;
  logic             reuse_w = 1'b0;
  logic             busy, done, w_rd_en, pe_load, a_rd_en;
  logic [VEC_W-1:0] a_rd_addr;
  logic [COLS-1:0]  out_valid;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS),
    .VEC_W(VEC_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_num_vec  (num_vec),
`ifdef WEIGHT_REUSE_EN
    .i_reuse_w  (reuse_w),
`endif
    .o_busy     (busy),
    .o_done     (done),
    .o_w_rd_en  (w_rd_en),
    .o_pe_load  (pe_load),
    .o_a_rd_en  (a_rd_en),
    .o_a_rd_addr(a_rd_addr),
    .o_out_valid(out_valid)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Reference job: job_s is the cycle in which start was sampled (cycle 0).
  bit job_valid = 1'b0;
  int job_s = 0;
  int job_n = 0;
  bit job_reuse = 1'b0;

  function automatic int job_len();
    int f;
    f = job_reuse ? 1 : 3;
    return (job_n == 0) ? 1 : f + ROWS + COLS + job_n;
  endfunction

  function automatic bit model_idle(int k);
    return !job_valid || (k - job_s) > job_len();
  endfunction

  function automatic logic [31:0] model_out(int k);
    int rel, f, d;
    logic bz, dn, wr, ld, aen;
    logic [15:0] addr;
    logic [3:0]  ov;
    bz = 0; dn = 0; wr = 0; ld = 0; aen = 0; addr = '0; ov = '0;
    if (job_valid) begin
      rel = k - job_s;
      f   = job_reuse ? 1 : 3;
      d   = job_len();
      bz  = (rel >= 1) && (rel <= d);
      dn  = (rel == d);
      if (job_n > 0) begin
        wr  = !job_reuse && (rel == 1);
        ld  = !job_reuse && (rel == 2);
        aen = (rel >= f) && (rel <= f + job_n - 1);
        if (aen) addr = 16'(rel - f);
        for (int c = 0; c < COLS; c++) begin
          ov[c] = (rel >= f + 1 + ROWS + c) && (rel <= f + ROWS + c + job_n);
        end
      end
    end
    return {7'b0, bz, dn, wr, ld, aen, addr, ov};
  endfunction

  function automatic logic [31:0] dut_out();
    return {7'b0, busy, done, w_rd_en, pe_load, a_rd_en, a_rd_addr, out_valid};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n && start && model_idle(cyc)) begin
      job_valid = 1'b1;
      job_s     = cyc;
      job_n     = int'(num_vec);
`ifdef WEIGHT_REUSE_EN
      job_reuse = reuse_w;
`else
      job_reuse = 1'b0;
`endif
    end
    cyc++;
    #1;
    check_eq($sformatf("cyc%0d", cyc), dut_out(), model_out(cyc));
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1 check_eq(tag, dut_out(), 32'h0);
    job_valid = 1'b0;
  endtask

  initial begin
    int s0;
    int d;
    // Reset held with start high: outputs stay 0.
    rst_n = 1'b0; start = 1'b1; num_vec = 8;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    // Nominal N=8 job with extra start pulses while busy and in DONE.
    s0 = job_s;
    while (cyc - s0 <= 20) begin
      start   = ((cyc - s0) == 5) || ((cyc - s0) == 19) || ((cyc - s0) == 20);
      num_vec = ((cyc - s0) == 20) ? 16'd3 : 16'd5;
      step();
    end
    start = 1'b0;
    repeat (18) step();

    // N=0 job.
    start = 1'b1; num_vec = 0;
    step();
    start = 1'b0;
    repeat (4) step();

    // Async reset mid-job, then a clean restart with N=1.
    start = 1'b1; num_vec = 8;
    step();
    start = 1'b0;
    repeat (11) step();
    async_reset("midjob_rst");
    repeat (2) step();
    rst_n = 1'b1;
    start = 1'b1; num_vec = 1;
    step();
    start = 1'b0;
    repeat (14) step();

`ifdef WEIGHT_REUSE_EN
    reuse_w = 1'b1; start = 1'b1; num_vec = 4;
    step();
    start = 1'b0;
    repeat (15) step();
    reuse_w = 1'b0;
`endif

    // Random traffic with occasional asynchronous resets.
    repeat (800) begin
      start   = ($urandom_range(0, 3) == 0);
      num_vec = 16'($urandom_range(0, 12));
`ifdef WEIGHT_REUSE_EN
      reuse_w = $urandom_range(0, 1) == 1;
`endif
      step();
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_rst");
        start = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    reuse_w = 1'b0;
    repeat (30) step();

    // Maximum vector count: counters must not wrap.
    start = 1'b1; num_vec = '1;
    step();
    start = 1'b0;
    d = job_len();
    repeat (d + 1) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
